// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the multi-cycle serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slice cycles needed to cover the whole operand.
    function automatic int unsigned steps(input int unsigned n, input int unsigned w);
        return n / w;
    endfunction

    function automatic bit width_ok(input int unsigned n, input int unsigned w);
        return (w != 0) && (w <= n) && ((n % w) == 0);
    endfunction

endpackage

// File: rtl/full_subtractor_wbit.sv
// W-bit combinational ripple-borrow subtractor slice: d = a - b - bin.
module full_subtractor_wbit #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bin;
        for (int i = 0; i < int'(W); i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
        bout = br[W];
    end

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Serial N-bit subtractor, W bits per clock, LSB slice first, start/done handshake.
// Optional signed-overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_nbit
    import serial_sub_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic         ovf,
`endif
    output logic         Bout
);

    localparam int unsigned STEPS = steps(N, W);
    localparam int unsigned CW    = $clog2(STEPS + 1);

    if (!width_ok(N, W)) begin : g_bad_width
        $error("serial_subtractor_nbit: N must be a non-zero multiple of W");
    end

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   a_sr, b_sr, diff_sr, diff_shift;
    logic           borrow;
    logic [W-1:0]   slice_d;
    logic           slice_b;
    logic           accept, step, finish;
    logic           ready_nx, busy_nx, done_nx;

    full_subtractor_wbit #(.W(W)) u_slice (
        .a    (a_sr[W-1:0]),
        .b    (b_sr[W-1:0]),
        .bin  (borrow),
        .d    (slice_d),
        .bout (slice_b)
    );

    // New slice result enters the difference register from the MSB end.
    always_comb begin
        diff_shift = diff_sr >> W;
        diff_shift[N-1 -: W] = slice_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // DONE is entered with ready low; the first DONE cycle publishes the result.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        ready_nx = ready;
        case (state)
            IDLE: begin
                accept = start && ready;
                if (accept) state_nx = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(STEPS - 1)) state_nx = DONE;
            end
            DONE: begin
                finish = !ready;
                accept = start && ready;
                if (accept) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
        if (accept)      ready_nx = 1'b0;
        else if (finish) ready_nx = 1'b1;
        busy_nx = (state_nx == RUN);
        done_nx = finish;
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_sign, b_sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                a_sign <= A[N-1];
                b_sign <= B[N-1];
            end
            if (finish) ovf <= (a_sign != b_sign) && (diff_sr[N-1] != a_sign);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            Diff    <= '0;
            Bout    <= 1'b0;
        end else begin
            ready <= ready_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            if (accept) begin
                a_sr   <= A;
                b_sr   <= B;
                borrow <= Bin;
                cnt    <= '0;
            end else if (step) begin
                a_sr    <= a_sr >> W;
                b_sr    <= b_sr >> W;
                borrow  <= slice_b;
                diff_sr <= diff_shift;
                cnt     <= cnt + CW'(1);
            end
            if (finish) begin
                Diff <= diff_sr;
                Bout <= borrow;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Bench for serial_subtractor_nbit at W=1, 4 and 8 against a cycle-level reference model.
module tb_serial_subtractor_nbit;

    localparam int unsigned N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, bin;
    logic [N-1:0] a, b;
    logic         ready [3];
    logic         busy  [3];
    logic         done  [3];
    logic         bout  [3];
    logic [N-1:0] diff  [3];
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf   [3];
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor_nbit #(.N(N), .W(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Bin(bin),
        .ready(ready[0]), .busy(busy[0]), .done(done[0]), .Diff(diff[0]),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf(ovf[0]),
`endif
        .Bout(bout[0]));

    serial_subtractor_nbit #(.N(N), .W(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Bin(bin),
        .ready(ready[1]), .busy(busy[1]), .done(done[1]), .Diff(diff[1]),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf(ovf[1]),
`endif
        .Bout(bout[1]));

    serial_subtractor_nbit #(.N(N), .W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Bin(bin),
        .ready(ready[2]), .busy(busy[2]), .done(done[2]), .Diff(diff[2]),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf(ovf[2]),
`endif
        .Bout(bout[2]));

    int unsigned wid     [3] = '{1, 4, 8};
    int unsigned steps_of[3] = '{32, 8, 4};

    // Reference model: one pending operation per instance, completing steps+1 edges after acceptance.
    bit           m_ready [3];
    bit           m_pend  [3];
    bit           m_done  [3];
    int unsigned  m_cnt   [3];
    logic [N-1:0] m_diff  [3];
    logic [N-1:0] m_nd    [3];
    bit           m_bout  [3];
    bit           m_nb    [3];
    bit           m_ovf   [3];
    bit           m_no    [3];

    function automatic bit exp_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic z);
        logic [N-1:0] r;
        r = x - y - N'(z);
        return (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_ready[i] <= 1'b1;
                m_pend[i]  <= 1'b0;
                m_done[i]  <= 1'b0;
                m_cnt[i]   <= 0;
                m_diff[i]  <= '0;
                m_bout[i]  <= 1'b0;
                m_ovf[i]   <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_pend[i]) begin
                    m_cnt[i] <= m_cnt[i] + 1;
                    if (m_cnt[i] == steps_of[i]) begin
                        m_pend[i]  <= 1'b0;
                        m_ready[i] <= 1'b1;
                        m_done[i]  <= 1'b1;
                        m_diff[i]  <= m_nd[i];
                        m_bout[i]  <= m_nb[i];
                        m_ovf[i]   <= m_no[i];
                    end
                end else if (start && m_ready[i]) begin
                    m_pend[i]  <= 1'b1;
                    m_ready[i] <= 1'b0;
                    m_cnt[i]   <= 0;
                    m_nd[i]    <= a - b - N'(bin);
                    m_nb[i]    <= ({1'b0, a} < ({1'b0, b} + 33'(bin)));
                    m_no[i]    <= exp_ovf(a, b, bin);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w%0d_ready", wid[i]), 64'(ready[i]), 64'(m_ready[i]));
            chk($sformatf("w%0d_busy", wid[i]), 64'(busy[i]),
                64'(m_pend[i] && (m_cnt[i] < steps_of[i])));
            chk($sformatf("w%0d_done", wid[i]), 64'(done[i]), 64'(m_done[i]));
            chk($sformatf("w%0d_diff", wid[i]), 64'(diff[i]), 64'(m_diff[i]));
            chk($sformatf("w%0d_bout", wid[i]), 64'(bout[i]), 64'(m_bout[i]));
`ifdef SERIAL_SUB_OVERFLOW_EN
            chk($sformatf("w%0d_ovf", wid[i]), 64'(ovf[i]), 64'(m_ovf[i]));
`endif
        end
    end

    task automatic drive_start(input logic [N-1:0] x, input logic [N-1:0] y, input logic z);
        a = x; b = y; bin = z; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
    endtask

    // Counts edges from the accepting edge until each instance pulses done.
    task automatic wait_all(input int budget, output int l0, output int l1, output int l2,
                            output int bn);
        int l[3];
        l  = '{-1, -1, -1};
        bn = busy[0] ? 1 : 0;
        for (int e = 1; e <= budget && (l[0] < 0 || l[1] < 0 || l[2] < 0); e++) begin
            @(posedge clk);
            #3;
            for (int i = 0; i < 3; i++) if (l[i] < 0 && done[i]) l[i] = e;
            if (busy[0]) bn++;
        end
        for (int i = 0; i < 3; i++) begin
            if (l[i] < 0) begin
                checks++;
                errors++;
                $display("FAIL w%0d_done_timeout actual=none required=done within %0d cycles",
                         wid[i], budget);
            end
        end
        l0 = l[0]; l1 = l[1]; l2 = l[2];
    endtask

    task automatic chk_all(input string nm, input logic [N-1:0] d, input logic bo);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_w%0d_diff", nm, wid[i]), 64'(diff[i]), 64'(d));
            chk($sformatf("%s_w%0d_bout", nm, wid[i]), 64'(bout[i]), 64'(bo));
        end
    endtask

    initial begin
        int l0, l1, l2, bn, seen;
        logic [N-1:0] x, y;
        logic z;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 64'(ready[i]), 64'd1);
            chk("rst_busy", 64'(busy[i]), 64'd0);
            chk("rst_diff", 64'(diff[i]), 64'd0);
        end
        rst_n = 1'b1;

        @(posedge clk);
        #2;
        drive_start(32'h0000_000A, 32'h0000_0003, 1'b0);
        wait_all(60, l0, l1, l2, bn);
        chk("lat_w1", 64'(l0), 64'd33);
        chk("lat_w4", 64'(l1), 64'd9);
        chk("lat_w8", 64'(l2), 64'd5);
        chk("busy_cycles_w1", 64'(bn), 64'd32);
        chk_all("sub10_3", 32'h0000_0007, 1'b0);

        drive_start(32'h0, 32'h0, 1'b1);
        wait_all(60, l0, l1, l2, bn);
        chk("b2b_lat_w1", 64'(l0), 64'd33);
        chk_all("wrap", 32'hFFFF_FFFF, 1'b1);

        drive_start(32'd5, 32'd9, 1'b0);
        wait_all(60, l0, l1, l2, bn);
        chk_all("sub5_9", 32'hFFFF_FFFC, 1'b1);

`ifdef SERIAL_SUB_OVERFLOW_EN
        drive_start(32'h8000_0000, 32'h1, 1'b0);
        wait_all(60, l0, l1, l2, bn);
        chk_all("ovf_neg", 32'h7FFF_FFFF, 1'b0);
        for (int i = 0; i < 3; i++) chk("ovf_neg_flag", 64'(ovf[i]), 64'd1);
        drive_start(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_all(60, l0, l1, l2, bn);
        chk_all("ovf_pos", 32'h8000_0000, 1'b1);
        for (int i = 0; i < 3; i++) chk("ovf_pos_flag", 64'(ovf[i]), 64'd1);
`else
        for (int i = 0; i < 3; i++) chk("no_ovf_build_ready", 64'(ready[i]), 64'd1);
`endif

        // Second start lands at W=1 RUN cycle 10 and must be ignored there.
        @(posedge clk);
        #2;
        drive_start(32'd1000, 32'd1, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        drive_start(32'd77, 32'd5, 1'b1);
        wait_all(60, l0, l1, l2, bn);
        chk("ignored_lat_w1", 64'(l0), 64'd23);
        chk("ignored_w1_diff", 64'(diff[0]), 64'd999);
        chk("ignored_w4_diff", 64'(diff[1]), 64'd71);

        drive_start(32'h1234_5678, 32'h0000_FFFF, 1'b0);
        wait_all(60, l0, l1, l2, bn);
        chk("wide_lat_w1", 64'(l0), 64'd33);
        chk("wide_lat_w4", 64'(l1), 64'd9);
        chk("wide_lat_w8", 64'(l2), 64'd5);
        chk_all("wide", 32'h1233_5679, 1'b0);

        // Reset in the middle of RUN aborts without a done pulse.
        @(posedge clk);
        #2;
        drive_start(32'd500, 32'd3, 1'b0);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_ready", 64'(ready[i]), 64'd1);
            chk("midrst_busy", 64'(busy[i]), 64'd0);
            chk("midrst_done", 64'(done[i]), 64'd0);
            chk("midrst_diff", 64'(diff[i]), 64'd0);
            chk("midrst_bout", 64'(bout[i]), 64'd0);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #3;
            if (done[0] || done[1] || done[2]) seen++;
        end
        chk("no_done_after_rst", 64'(seen), 64'd0);
        drive_start(32'd100, 32'd1, 1'b0);
        wait_all(60, l0, l1, l2, bn);
        chk_all("post_rst", 32'd99, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            x = $urandom; y = $urandom; z = 1'($urandom);
            if ($urandom_range(7, 0) == 0) x = ($urandom_range(1, 0) != 0) ? '0 : '1;
            if ($urandom_range(7, 0) == 0) y = ($urandom_range(1, 0) != 0) ? '0 : '1;
            drive_start(x, y, z);
            wait_all(60, l0, l1, l2, bn);
            chk_all("rnd", x - y - N'(z), ({1'b0, x} < ({1'b0, y} + 33'(z))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_nbit.md
Name: serial_subtractor_nbit

Overview:
Multi-cycle ripple-borrow subtractor that computes Diff = A - B - Bin over N-bit operands, W bits per clock, LSB slice first. It is the inverse datapath of the team's combinational N-bit full adder and shares its operand width conventions. A start/done handshake lets a testbench or controller issue one subtraction at a time. The slice logic is reused from a small combinational full-subtractor sub-module.

Parameters:
N, 32, operand width in bits; must be an integer multiple of W
W, 1, bits processed per clock (slice width); legal values are 1, 2, 4, 8, up to N

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new subtraction; accepted only when ready=1
A  input  N  minuend, sampled on the accepted start
B  input  N  subtrahend, sampled on the accepted start
Bin  input  1  borrow-in, sampled on the accepted start
ready  output  1  high in IDLE and DONE; start is accepted when ready=1
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when Diff/Bout become valid
Diff  output  N  difference, valid from the done pulse until the next accepted start
Bout  output  1  final borrow-out (1 when A < B + Bin, unsigned)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; ready=1, busy=0, done=0, Diff=0, Bout=0; internal shift registers and step counter cleared.
- States: IDLE, RUN, DONE.
- IDLE with start=1: latch A, B, Bin into shift registers; clear the step counter; go to RUN. With start=0: stay in IDLE.
- RUN: each cycle, the W-bit slice computes d = a_slice - b_slice - borrow. The result shifts into the Diff register from the MSB end. The borrow register is updated. The step counter increments.
- RUN exit: after exactly N/W RUN cycles, go to DONE. done=1 for the single cycle in which the state becomes DONE.
- Latency: start sampled at edge k, so done is high after edge k+N/W+1. For N=32, W=1 this is 33 cycles.
- DONE: Diff and Bout are held stable. start=1 is accepted exactly as in IDLE, which allows back-to-back operations. Otherwise the block stays in DONE; it never returns to IDLE except through reset.
- start while busy=1 is ignored: no effect on state or operands.
- Arithmetic: all slice math is modulo 2^W with a 1-bit borrow. The final result equals (A - B - Bin) mod 2^N. Bout=1 if and only if A < B + Bin, computed as unsigned arithmetic in N+1 bits.
- Wrap-around: A=0, B=0, Bin=1 gives Diff = all-ones and Bout=1.
- Reset mid-RUN: the operation is aborted immediately and all outputs return to their reset values. No done pulse is produced.
- A, B and Bin may change freely after they are accepted; they have no effect until the next accepted start.

Optional Feature:
Macro SERIAL_SUB_OVERFLOW_EN.
- When defined: an extra output port ovf (output, 1 bit) is added. It reports two's-complement signed overflow: (A[N-1] != B[N-1]) && (Diff[N-1] != A[N-1]). The signs are captured at start. ovf is valid and changes together with done, is held in DONE, and resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - state enum {IDLE, RUN, DONE}
  - function steps(N, W) returning N/W
  - elaboration-time check that N % W == 0
- Sub-module full_subtractor_wbit #(W): purely combinational.
  - inputs: a[W-1:0], b[W-1:0], bin
  - outputs: d[W-1:0], bout
  - ripple of W 1-bit full subtractors with d = a^b^bin and bout = (~a&b) | (~(a^b)&bin)
- The top level holds the FSM, the step counter, and the operand and result shift registers.

Test Plan:
- N=32, W=1; A=0x0000_000A, B=0x0000_0003, Bin=0, pulse start -> done after 33 cycles, Diff=0x0000_0007, Bout=0, busy high for 32 cycles.
- A=0, B=0, Bin=1 -> Diff=0xFFFF_FFFF, Bout=1. Also A=5, B=9, Bin=0 -> Diff=0xFFFF_FFFC, Bout=1.
- With SERIAL_SUB_OVERFLOW_EN defined: A=0x8000_0000, B=1, Bin=0 -> Diff=0x7FFF_FFFF, Bout=0, ovf=1. Also A=0x7FFF_FFFF, B=0xFFFF_FFFF -> Diff=0x8000_0000, ovf=1.
- Assert start at cycle 10 of RUN with different operands -> ignored; the original result is produced. Then issue start on the done cycle (back-to-back) -> the second result follows 33 cycles later.
- Drive rst_n low at RUN cycle 15 -> outputs go to their reset values immediately with no done pulse. Then release reset and run A=100, B=1 -> Diff=99.
- Repeat with W=4 and W=8: 0x1234_5678 - 0x0000_FFFF -> Diff=0x1233_5679, Bout=0, latency 9 and 5 cycles respectively. Follow with 1000 random vectors checked against (A-B-Bin) mod 2^32.
